// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word fetches and
// buffers in-order responses in a prefetch FIFO. Optional macro: FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirectPC,
  output logic                   imemReq,
  output logic [ADDR_WIDTH-1:0]  imemAddr,
  input  logic                   imemGnt,
  input  logic                   imemRValid,
  input  logic [INSTR_WIDTH-1:0] imemRData,
  output logic                   ifValid,
  output logic [ADDR_WIDTH-1:0]  ifPC,
  output logic [INSTR_WIDTH-1:0] ifInstr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            perfStallCycles,
  output logic [31:0]            perfDropCount
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0]  PC_STEP = ADDR_WIDTH'(4);
  localparam logic [INSTR_WIDTH-1:0] NOP     = INSTR_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {BOOT, FETCH, FLUSH} state_t;

  state_t                  state, stateNext;
  logic [ADDR_WIDTH-1:0]   fetchPC, fetchPCNext;
  logic [ADDR_WIDTH-1:0]   respPC, respPCNext;
  logic [ADDR_WIDTH-1:0]   pendingPC, pendingPCNext;
  logic [CW-1:0]           outstanding, outstandingNext;
  logic [CW-1:0]           dropCnt, dropCntNext;
  logic [CW-1:0]           fifoCount;
  logic [PW-1:0]           rdPtr, wrPtr;
  logic [ADDR_WIDTH-1:0]   fifoPC    [FIFO_DEPTH];
  logic [INSTR_WIDTH-1:0]  fifoInstr [FIFO_DEPTH];

  logic [CW:0]             credit;
  logic [ADDR_WIDTH-1:0]   target;
  logic                    grant, push, pop, drop, clearFifo;

  // Credits cover both in-flight requests and buffered entries, so a push never overflows.
  assign credit   = {1'b0, outstanding} + {1'b0, fifoCount};
  assign imemReq  = (state == FETCH) && (credit < (CW+1)'(FIFO_DEPTH));
  assign imemAddr = fetchPC;
  assign grant    = imemReq && imemGnt;
  assign target   = redirectPC & ~ADDR_WIDTH'(3);

  assign ifValid  = (fifoCount != '0);
  assign ifPC     = ifValid ? fifoPC[rdPtr] : '0;
  assign ifInstr  = ifValid ? fifoInstr[rdPtr] : NOP;
  assign pop      = ifValid && !stall && !redirect;

  always_comb begin
    stateNext       = state;
    fetchPCNext     = fetchPC;
    respPCNext      = respPC;
    pendingPCNext   = pendingPC;
    dropCntNext     = dropCnt;
    outstandingNext = outstanding + CW'(grant) - CW'(imemRValid);
    push            = 1'b0;
    drop            = 1'b0;
    clearFifo       = 1'b0;

    case (state)
      BOOT: stateNext = FETCH;
      FETCH: begin
        if (grant) fetchPCNext = fetchPC + PC_STEP;
        if (imemRValid) begin
          push       = 1'b1;
          respPCNext = respPC + PC_STEP;
        end
      end
      FLUSH: begin
        if (imemRValid) begin
          drop        = 1'b1;
          dropCntNext = dropCnt - CW'(1);
          if (dropCntNext == '0) begin
            stateNext   = FETCH;
            fetchPCNext = pendingPC;
            respPCNext  = pendingPC;
          end
        end
      end
      default: stateNext = BOOT;
    endcase

    // Redirect overrides everything above: wrong-path data is dropped, grants still count.
    if (redirect) begin
      push        = 1'b0;
      drop        = imemRValid;
      clearFifo   = 1'b1;
      dropCntNext = outstandingNext;
      if (outstandingNext == '0) begin
        stateNext   = FETCH;
        fetchPCNext = target;
        respPCNext  = target;
      end else begin
        stateNext     = FLUSH;
        fetchPCNext   = fetchPC;
        pendingPCNext = target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      fetchPC     <= RESET_PC;
      respPC      <= RESET_PC;
      pendingPC   <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      state       <= stateNext;
      fetchPC     <= fetchPCNext;
      respPC      <= respPCNext;
      pendingPC   <= pendingPCNext;
      outstanding <= outstandingNext;
      dropCnt     <= dropCntNext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifoCount <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
    end else if (clearFifo) begin
      fifoCount <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      fifoCount <= fifoCount + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only visible through fifoCount.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoPC[wrPtr]    <= respPC;
      fifoInstr[wrPtr] <= imemRData;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perfStallCycles <= '0;
      perfDropCount   <= '0;
    end else begin
      if (imemReq && !imemGnt && (perfStallCycles != '1))
        perfStallCycles <= perfStallCycles + 32'd1;
      if (drop && (perfDropCount != '1))
        perfDropCount <= perfDropCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan steps then randomized traffic against
// a transaction-level model (expected PC stream, in-flight request queue, FIFO occupancy).
module tb_fetch_stage;

  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk, reset, stall, redirect, imemReq, imemGnt, imemRValid, ifValid;
  logic [31:0] redirectPC, imemAddr, imemRData, ifPC, ifInstr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfStallCycles, perfDropCount;
`endif

  fetch_stage #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemGnt(imemGnt), .imemRValid(imemRValid),
    .imemRData(imemRData), .ifValid(ifValid), .ifPC(ifPC), .ifInstr(ifInstr)
`ifdef FETCH_PERF_CNT_EN
    , .perfStallCycles(perfStallCycles), .perfDropCount(perfDropCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } req_t;

  req_t        q[$];
  int          checkCount = 0, passCount = 0, failCount = 0;
  int          cyc = 0, lat = 1, modelCnt = 0, dropPending = 0;
  int          perfStallExp = 0, perfDropExp = 0;
  logic [31:0] expPC = 0, expFetch = 0;
  logic        boot = 1'b1, saw200 = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic resetModel();
    q.delete();
    modelCnt = 0; dropPending = 0; expPC = 0; expFetch = 0; boot = 1'b1;
    perfStallExp = 0; perfDropExp = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, update the model.
  task automatic tick(input logic st, input logic gn, input logic rd, input logic [31:0] rpc);
    logic grant, rv, dropping, pop;
    stall = st; imemGnt = gn; redirect = rd; redirectPC = rpc;
    if (q.size() > 0 && q[0].ready <= cyc) begin
      imemRValid = 1'b1; imemRData = memf(q[0].addr);
    end else begin
      imemRValid = 1'b0; imemRData = $urandom;
    end
    #1;
    if (boot) check("boot_req", imemReq, 0);
    else if (dropPending > 0) check("flush_req", imemReq, 0);
    else check("credit_req", imemReq, (q.size() + modelCnt) < FIFO_DEPTH);
    if (imemReq) check("fetch_addr", imemAddr, expFetch);
    check("if_valid", ifValid, modelCnt != 0);
    if (!ifValid) check("nop", ifInstr, NOP);
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall", perfStallCycles, perfStallExp);
    check("perf_drop_run", perfDropCount, perfDropExp);
`endif
    grant    = imemReq && imemGnt;
    rv       = imemRValid;
    pop      = ifValid && !stall && !redirect;
    dropping = rv && (redirect || dropPending > 0);
    if (pop) begin
      check("if_pc", ifPC, expPC);
      check("if_instr", ifInstr, memf(expPC));
      expPC += 4;
    end
    if (grant) begin
      if (imemAddr == 32'h200) saw200 = 1'b1;
      q.push_back('{imemAddr, cyc + lat});
      expFetch += 4;
    end
    if (rv) void'(q.pop_front());
    if (imemReq && !imemGnt) perfStallExp++;
    if (dropping) perfDropExp++;
    if (rd) begin
      modelCnt    = 0;
      dropPending = q.size();
      expPC       = rpc & ~32'd3;
      expFetch    = rpc & ~32'd3;
    end else begin
      if (rv && !dropping) begin
        modelCnt++;
        check("no_overflow", modelCnt <= FIFO_DEPTH, 1);
      end
      if (pop) modelCnt--;
      if (dropping) dropPending--;
    end
    boot = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (q.size() != 0 || modelCnt != 0); i++) tick(0, 0, 0, 0);
    check("drain_done", ifValid, 0);
  endtask

  task automatic resetChecks(input string tag);
    check({tag, "_req"}, imemReq, 0);
    check({tag, "_addr"}, imemAddr, 32'h0);
    check({tag, "_valid"}, ifValid, 0);
    check({tag, "_pc"}, ifPC, 32'h0);
    check({tag, "_instr"}, ifInstr, NOP);
  endtask

  initial begin
    int          firstValid;
    logic [31:0] pcHold, insHold, perfBase;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPC = '0;
    imemGnt = 1'b0; imemRValid = 1'b0; imemRData = '0;
    perfBase = '0;
    repeat (3) @(negedge clk);
    resetChecks("reset");
    reset = 1'b0;
    resetModel();

    // Straight-line fetch, always granted, 1-cycle memory.
    lat = 1; firstValid = -1;
    for (int k = 0; k < 20; k++) begin
      if (ifValid && firstValid < 0) firstValid = k;
      tick(0, 1, 0, 0);
    end
    check("first_valid", firstValid, 3);

    // Stall five cycles with a valid head: outputs hold, credit throttles requests.
    for (int i = 0; i < 5 && !ifValid; i++) tick(0, 1, 0, 0);
    pcHold = ifPC; insHold = ifInstr;
    for (int j = 0; j < 5; j++) begin
      check("stall_pc", ifPC, pcHold);
      check("stall_instr", ifInstr, insHold);
      tick(1, 1, 0, 0);
    end
    repeat (10) tick(0, 1, 0, 0);

    // Redirect with nothing in flight.
    drain();
    tick(0, 0, 1, 32'h100);
    check("redir0_req", imemReq, 1);
    check("redir0_addr", imemAddr, 32'h100);
    repeat (10) tick(0, 1, 0, 0);

    // Redirect with two in flight; responses come back 3 and 4 cycles later.
    drain();
`ifdef FETCH_PERF_CNT_EN
    perfBase = perfDropCount;
`endif
    lat = 5;
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 32'h200);
    lat = 1;
    repeat (4) tick(0, 1, 0, 0);
    check("redir2_req", imemReq, 1);
    check("redir2_addr", imemAddr, 32'h200);
`ifdef FETCH_PERF_CNT_EN
    check("perf_drop2", perfDropCount - perfBase, 2);
`endif
    repeat (10) tick(0, 1, 0, 0);

    // Second redirect while flushing replaces the target.
    drain();
    saw200 = 1'b0; lat = 5;
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 32'h200);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 32'h303);
    lat = 1;
    repeat (2) tick(0, 1, 0, 0);
    check("redir3_req", imemReq, 1);
    check("redir3_addr", imemAddr, 32'h300);
    repeat (10) tick(0, 1, 0, 0);
    check("never_200", saw200, 0);

    // Asynchronous reset with one response outstanding and a buffered entry.
    lat = 3;
    for (int i = 0; i < 30 && !(q.size() == 1 && modelCnt == 1); i++) tick(1, 1, 0, 0);
    check("midreset_setup", ifValid, 1);
    #2 reset = 1'b1;
    #1 resetChecks("midreset");
    imemGnt = 1'b0; imemRValid = 1'b0; stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    resetModel();
    lat = 1;
    repeat (12) tick(0, 1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      lat = $urandom_range(1, 4);
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passCount, checkCount);
    $fatal(1, "watchdog expired");
  end

endmodule
